// File: rtl/mem_scan_ctrl.sv
// Debug read sequencer for the board wrapper: drives the testbench memory
// port while the CPU is halted, in manual single-read or timed auto-scan mode.
module mem_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES   = 50000000,
  parameter int unsigned SCAN_WORDS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        auto_mode,
  input  logic        start,
  input  logic [15:0] sw_addr,
  input  logic        mem_ready,
  input  logic [31:0] load,
  output logic        tb_ctrl,
  output logic        ren,
  output logic [31:0] addr,
  output logic [31:0] disp_data,
  output logic [15:0] disp_addr,
  output logic        busy,
  output logic        err
);

  localparam int WC_W = (SCAN_WORDS > 1) ? $clog2(SCAN_WORDS) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_LAST    = WC_W'(SCAN_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      ERR_WORD   = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              tb_ctrl_q, tb_ctrl_d;
  logic              scan_q, scan_d;
  logic              err_q, err_d;
  logic [15:0]       cur_addr_q, cur_addr_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic [15:0]       disp_addr_q, disp_addr_d;

  logic              start_rise;
  logic [15:0]       sw_aligned;
  logic              go;

  assign start_rise = start & ~start_q;
  assign sw_aligned = sw_addr & 16'hFFFC;

  // Manual mode also re-reads when the switches select a new word.
  assign go = halt & (auto_mode ? start_rise
                                : (start_rise | (sw_aligned != disp_addr_q)));

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    tb_ctrl_d   = halt;
    scan_d      = scan_q;
    err_d       = err_q;
    cur_addr_d  = cur_addr_q;
    word_cnt_d  = word_cnt_q;
    dwell_d     = dwell_q;
    tmo_d       = tmo_q;
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_addr_d = sw_aligned;
          word_cnt_d = '0;
          scan_d     = auto_mode;
          if (start_rise) err_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (!halt) begin
          scan_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!halt) begin
          scan_d  = 1'b0;
          state_d = S_IDLE;
        end else if (mem_ready) begin
          disp_data_d = load;
          disp_addr_d = cur_addr_q;
          if (scan_q) begin
            dwell_d = '0;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo_q == TO_LAST) begin
          err_d       = 1'b1;
          disp_data_d = ERR_WORD;
          scan_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      S_HOLD: begin
        if (!halt || start_rise) begin
          scan_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dwell_q == DWELL_LAST) begin
          if (word_cnt_q == WC_LAST) begin
            scan_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // 16-bit add wraps FFFC back to 0000.
            cur_addr_d = cur_addr_q + 16'd4;
            word_cnt_d = word_cnt_q + WC_W'(1);
            state_d    = S_REQ;
          end
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      default: begin
        scan_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      tb_ctrl_q   <= 1'b0;
      scan_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr_q  <= '0;
      word_cnt_q  <= '0;
      dwell_q     <= '0;
      tmo_q       <= '0;
      disp_data_q <= '0;
      disp_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      tb_ctrl_q   <= tb_ctrl_d;
      scan_q      <= scan_d;
      err_q       <= err_d;
      cur_addr_q  <= cur_addr_d;
      word_cnt_q  <= word_cnt_d;
      dwell_q     <= dwell_d;
      tmo_q       <= tmo_d;
      disp_data_q <= disp_data_d;
      disp_addr_q <= disp_addr_d;
    end
  end

  assign tb_ctrl   = tb_ctrl_q;
  assign ren       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign addr      = {16'h0000, cur_addr_q};
  assign disp_data = disp_data_q;
  assign disp_addr = disp_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: vector table, corner sequences and random
// transactions checked against a transaction-level reference model.
module tb_mem_scan_ctrl;

  localparam int DW = 4;
  localparam int SW = 3;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        auto_mode = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sw_addr = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] load = '0;
  logic        tb_ctrl, ren, busy, err;
  logic [31:0] addr, disp_data;
  logic [15:0] disp_addr;

  mem_scan_ctrl #(
    .DWELL_CYCLES(DW),
    .SCAN_WORDS(SW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(4)
  ) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .auto_mode(auto_mode),
    .start(start), .sw_addr(sw_addr), .mem_ready(mem_ready),
    .load(load), .tb_ctrl(tb_ctrl), .ren(ren), .addr(addr),
    .disp_data(disp_data), .disp_addr(disp_addr), .busy(busy),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int resp_lat = 1;
  int ren_run = 0;
  int ren_cnt = 0;
  int busy_cnt = 0;
  logic prev_ren = 1'b0;
  logic [31:0] salt = '0;
  logic [31:0] reads[$];

  typedef struct {
    logic [15:0] sw;
    logic        use_start;
    int          lat;
    logic [15:0] exp_a;
    logic [15:0] exp_daddr;
    int          exp_ren;
    logic        exp_err;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} ^ salt;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic bound_fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired", n);
  endtask

  // Memory responder and observers, all on the falling edge.
  task automatic step();
    @(negedge CLK);
    if (ren && !prev_ren) reads.push_back(addr);
    prev_ren = ren;
    ren_run = ren ? ren_run + 1 : 0;
    if (ren) ren_cnt++;
    if (busy) busy_cnt++;
    mem_ready = ren && (resp_lat > 0) && (ren_run == resp_lat + 1);
    load = mem_ready ? mem_word(addr[15:0]) : $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    reads.delete();
    ren_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string n, input int maxc);
    int k;
    k = 0;
    step();
    while (busy && k < maxc) begin
      step();
      k++;
    end
    chk({n, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_hold(input string n, input int nr);
    int k;
    k = 0;
    while (!(reads.size() == nr && !ren && busy) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) bound_fail({n, " hold"});
  endtask

  task automatic check_txn(input string n, input logic [15:0] ea[$],
                           input int e_ren, input int e_busy,
                           input logic [31:0] e_data,
                           input logic [15:0] e_daddr, input logic e_err);
    chk({n, " nreads"}, 32'(reads.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      chk({n, " addr"}, (i < reads.size()) ? reads[i] : 32'hFFFFFFFF,
          {16'h0, ea[i]});
    chk({n, " ren_cycles"}, 32'(ren_cnt), 32'(e_ren));
    chk({n, " busy_cycles"}, 32'(busy_cnt), 32'(e_busy));
    chk({n, " disp_data"}, disp_data, e_data);
    chk({n, " disp_addr"}, 32'(disp_addr), 32'(e_daddr));
    chk({n, " err"}, 32'(err), 32'(e_err));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] m_daddr;
    logic [15:0] base;
    int k;
    logic is_auto;

    tbl[0] = '{16'h0042, 1'b0,  3, 16'h0040, 16'h0040, 4, 1'b0};
    tbl[1] = '{16'h1237, 1'b0,  1, 16'h1234, 16'h1234, 2, 1'b0};
    tbl[2] = '{16'hFFFF, 1'b0,  5, 16'hFFFC, 16'hFFFC, 6, 1'b0};
    tbl[3] = '{16'h0003, 1'b0,  2, 16'h0000, 16'h0000, 3, 1'b0};
    tbl[4] = '{16'h0001, 1'b1, -1, 16'h0000, 16'h0000, 9, 1'b1};

    run(2);
    chk("rst tb_ctrl", 32'(tb_ctrl), 0);
    chk("rst ren", 32'(ren), 0);
    chk("rst addr", addr, 0);
    chk("rst disp_data", disp_data, 0);
    chk("rst disp_addr", 32'(disp_addr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err", 32'(err), 0);
    nRST = 1'b1;

    // Not halted: board controls must not touch the port.
    clr();
    sw_addr = 16'h1230;
    pulse_start();
    sw_addr = 16'h4444;
    run(5);
    chk("nohalt ren", 32'(ren_cnt), 0);
    chk("nohalt tb_ctrl", 32'(tb_ctrl), 0);
    chk("nohalt busy", 32'(busy_cnt), 0);

    sw_addr = 16'h0000;
    halt = 1'b1;
    run(2);
    chk("halt tb_ctrl", 32'(tb_ctrl), 1);
    chk("halt idle", 32'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      resp_lat = tbl[i].lat;
      salt = $urandom;
      clr();
      sw_addr = tbl[i].sw;
      if (tbl[i].use_start) pulse_start();
      wait_idle("tbl", 40);
      run(4);
      q.delete();
      q.push_back(tbl[i].exp_a);
      check_txn($sformatf("tbl%0d", i), q, tbl[i].exp_ren, tbl[i].exp_ren,
                tbl[i].exp_err ? 32'hDEADBEEF : mem_word(tbl[i].exp_a),
                tbl[i].exp_daddr, tbl[i].exp_err);
    end

    // Same address after timeout: no retrigger; start retries and clears err.
    clr();
    run(10);
    chk("tmo noretrig", 32'(reads.size()), 0);
    resp_lat = 1;
    pulse_start();
    wait_idle("tmo retry", 40);
    q.delete();
    q.push_back(16'h0000);
    check_txn("tmo retry", q, 2, 2, mem_word(16'h0000), 16'h0000, 1'b0);

    // Auto scan across the 16-bit wrap.
    auto_mode = 1'b1;
    sw_addr = 16'hFFF8;
    clr();
    run(5);
    chk("auto nostart", 32'(reads.size()), 0);
    salt = $urandom;
    resp_lat = 1;
    pulse_start();
    wait_idle("scan", 100);
    q.delete();
    q.push_back(16'hFFF8);
    q.push_back(16'hFFFC);
    q.push_back(16'h0000);
    check_txn("scan", q, 6, 18, mem_word(16'h0000), 16'h0000, 1'b0);

    // Halt dropped while holding word 1.
    sw_addr = 16'h0100;
    resp_lat = 2;
    salt = $urandom;
    clr();
    pulse_start();
    wait_hold("haltdrop", 2);
    halt = 1'b0;
    step();
    chk("haltdrop busy", 32'(busy), 0);
    chk("haltdrop ren", 32'(ren), 0);
    chk("haltdrop tb_ctrl", 32'(tb_ctrl), 0);
    chk("haltdrop data", disp_data, mem_word(16'h0104));
    chk("haltdrop daddr", 32'(disp_addr), 32'h0104);
    clr();
    run(8);
    chk("haltdrop quiet", 32'(reads.size()), 0);

    // start during HOLD aborts; next start restarts from the switches.
    halt = 1'b1;
    run(2);
    sw_addr = 16'h0200;
    resp_lat = 1;
    clr();
    pulse_start();
    wait_hold("abort", 1);
    pulse_start();
    chk("abort busy", 32'(busy), 0);
    run(5);
    chk("abort nreads", 32'(reads.size()), 1);
    clr();
    pulse_start();
    wait_idle("restart", 100);
    q.delete();
    q.push_back(16'h0200);
    q.push_back(16'h0204);
    q.push_back(16'h0208);
    check_txn("restart", q, 6, 18, mem_word(16'h0208), 16'h0208, 1'b0);

    // Asynchronous reset in the middle of a WAIT.
    auto_mode = 1'b0;
    resp_lat = -1;
    sw_addr = 16'h0A00;
    k = 0;
    while (ren_run < 3 && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) bound_fail("rstwait reach");
    nRST = 1'b0;
    sw_addr = 16'h0000;
    #1;
    chk("rstwait ren", 32'(ren), 0);
    chk("rstwait busy", 32'(busy), 0);
    chk("rstwait addr", addr, 0);
    chk("rstwait tb_ctrl", 32'(tb_ctrl), 0);
    chk("rstwait data", disp_data, 0);
    chk("rstwait daddr", 32'(disp_addr), 0);
    step();
    nRST = 1'b1;
    clr();
    run(3);
    chk("rstwait idle", 32'(busy_cnt), 0);
    chk("rstwait tb_ctrl1", 32'(tb_ctrl), 1);

    // Random transactions against a transaction-level model.
    m_daddr = 16'h0000;
    for (int t = 0; t < 24; t++) begin
      is_auto = 1'($urandom_range(0, 1));
      resp_lat = $urandom_range(1, 7);
      sw_addr = 16'($urandom);
      if (!is_auto && $urandom_range(0, 5) == 0) begin
        resp_lat = -1;
        sw_addr = {m_daddr[15:2], 2'($urandom)};
      end
      salt = $urandom;
      base = sw_addr & 16'hFFFC;
      auto_mode = is_auto;
      clr();
      pulse_start();
      wait_idle("rnd", 200);
      run(2);
      q.delete();
      if (is_auto) begin
        for (int w = 0; w < SW; w++) q.push_back(base + 16'(4 * w));
        m_daddr = q[SW-1];
        check_txn($sformatf("rnd%0d auto", t), q, SW * (resp_lat + 1),
                  SW * (resp_lat + 1 + DW), mem_word(m_daddr), m_daddr,
                  1'b0);
      end else if (resp_lat < 0) begin
        q.push_back(base);
        check_txn($sformatf("rnd%0d tmo", t), q, TO + 1, TO + 1,
                  32'hDEADBEEF, m_daddr, 1'b1);
      end else begin
        q.push_back(base);
        m_daddr = base;
        check_txn($sformatf("rnd%0d man", t), q, resp_lat + 1,
                  resp_lat + 1, mem_word(base), base, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_scan_ctrl.md
Name: mem_scan_ctrl

Overview:
Debug read controller for the board-level FPGA wrapper. It owns the system testbench memory port (tbCTRL/REN/addr/load) while the CPU is halted. It sequences word reads for the seven-segment display in two modes: manual (one switch-selected address) and auto-scan (a timed walk over a block of words). It sits between board controls (switches/keys) and the system interface, and replaces direct combinational tie-offs with a handshaked, timeout-protected read sequence.

Parameters:
DWELL_CYCLES, 50000000, cycles each word is held on display in auto-scan (1 s at 50 MHz)
SCAN_WORDS, 16, number of words visited per auto-scan pass
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ready before error
CNT_W, 26, width of dwell counter (must hold DWELL_CYCLES-1)

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
halt  in  1  CPU halted; port ownership only while 1
auto_mode  in  1  0=manual, 1=auto-scan
start  in  1  synchronous level from key; rising edge triggers action
sw_addr  in  16  manual address / scan base address (byte address)
mem_ready  in  1  memory returned valid load this cycle
load  in  32  memory read data
tb_ctrl  out  1  testbench port select
ren  out  1  memory read enable
addr  out  32  read address, {16'b0, cur_addr}
disp_data  out  32  latched word for HEX display
disp_addr  out  16  address of disp_data
busy  out  1  read or scan in progress
err  out  1  sticky read timeout flag

Behaviour:
- Reset (async, nRST=0): state IDLE; tb_ctrl=0, ren=0, addr=0, disp_data=0, disp_addr=0, busy=0, err=0, counters=0, start edge register=0.
- Word alignment: cur_addr[1:0] forced 2'b00; sw_addr[1:0] ignored.
- tb_ctrl = halt, registered (1-cycle latency). ren=1 only in REQ and WAIT.
- start_rise = start & ~start_q (start_q registered every cycle).
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: busy=0. If halt=1 and (manual mode: start_rise, or {sw_addr[15:2],2'b00} != disp_addr) -> cur_addr={sw_addr[15:2],2'b00}, word_cnt=0, err cleared on start_rise only, -> REQ. If halt=1, auto_mode=1, start_rise -> same load, scan flag=1, err cleared, -> REQ.
- REQ (1 cycle): drive addr, ren=1, timeout counter=0 -> WAIT.
- WAIT: ren held. mem_ready=1 -> disp_data<=load, disp_addr<=cur_addr; manual -> IDLE; auto -> HOLD with dwell=0. Timeout counter reaching TIMEOUT_CYCLES without mem_ready -> err=1, disp_data<=32'hDEADBEEF, scan aborted, -> IDLE.
- HOLD: dwell increments; at DWELL_CYCLES-1: if word_cnt==SCAN_WORDS-1 -> IDLE (scan complete, disp holds last word); else cur_addr+=4 (16-bit wrap: 16'hFFFC -> 16'h0000), word_cnt+=1, -> REQ.
- start_rise during HOLD aborts the scan -> IDLE. The next start_rise restarts from sw_addr.
- start_rise in REQ/WAIT is ignored.
- busy=1 in REQ, WAIT, HOLD.
- halt falling in any non-IDLE state: next cycle state=IDLE, ren=0; disp_data/disp_addr keep their last values; err unchanged.
- Manual mode, address-change retrigger: the comparison uses the aligned sw_addr vs disp_addr, so it causes no read loop after a successful read. After a timeout, disp_addr is unchanged, so an identical address retriggers no read until the switches change or start_rise.
- Switch changes during an auto-scan are ignored until IDLE.
- auto_mode change while busy takes effect only at the next IDLE decision.
- mem_ready outside WAIT is ignored.

Test Plan:
- Reset with nRST low mid-WAIT -> all outputs 0 immediately (async); state IDLE after release.
- halt=1, manual, sw_addr=16'h0042, mem_ready 3 cycles after REQ with load=32'h1234ABCD -> addr=32'h00000040, ren high 4 cycles, disp_data=32'h1234ABCD, disp_addr=16'h0040, busy low next cycle, no further read.
- Auto, DWELL_CYCLES=4, SCAN_WORDS=3, sw_addr=16'hFFF8, start pulse, mem_ready 1 cycle -> reads at FFF8, FFFC, 0000; each word held 4 cycles; busy drops after the third HOLD.
- mem_ready never asserted, TIMEOUT_CYCLES=8 -> err=1 and disp_data=32'hDEADBEEF after 8 WAIT cycles; next start_rise clears err.
- halt dropped during HOLD of word 1 of a scan -> IDLE, ren=0, tb_ctrl=0 one cycle later, disp_data retains word 1.
- halt=0 with start pulses and sw_addr changes -> no ren assertion, tb_ctrl=0.
